// File: rtl/fifo_serial_reader.sv
// fifo_serial_reader
// Read-side consumer for the 4-entry byte FIFO. Pops one byte at a time and
// sends it LSB-first on an asynchronous serial line:
// start bit, 8 data bits, optional even parity, stop bit.
//
// Build option: define FIFO_READER_PARITY_EN to compile in the PARITY state
// (11-bit frames). Without it, frames are 10 bits.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for tx_enable with a non-empty FIFO
// LOAD   | one cycle; fifo_pop high, head byte captured at exit edge
// START  | line low for one bit time
// DATA   | eight data bits, LSB first, from shift register bit 0
// PARITY | even parity of the captured byte (parity builds only)
// STOP   | line high for one bit time, then back to IDLE
//
// tx_line is registered from the current state, so the line lags the state
// register by one cycle. Frame durations and inter-frame gaps are unaffected.

module fifo_serial_reader #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_pop,
  output logic       tx_line,
  output logic       busy,
  output logic       byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef FIFO_READER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd5
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              byte_done_q, byte_done_d;
`ifdef FIFO_READER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic bit_end;
  logic counting;

  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state decode; a frame only starts from IDLE with data available.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end && (bit_cnt_q == 3'd7)) begin
`ifdef FIFO_READER_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef FIFO_READER_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Baud and bit counters: baud restarts on every state change and bit end.
  always_comb begin
    counting = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
`ifdef FIFO_READER_PARITY_EN
    counting = counting || (state_q == S_PARITY);
`endif
    baud_d = '0;
    if (counting && (state_d == state_q) && !bit_end) begin
      baud_d = baud_q + BAUD_W'(1);
    end

    bit_cnt_d = '0;
    if (state_q == S_DATA) begin
      bit_cnt_d = bit_end ? (bit_cnt_q + 3'd1) : bit_cnt_q;
    end
  end

  // Datapath: capture the pre-pop head in LOAD, shift right after each data bit.
  always_comb begin
    shift_d = shift_q;
`ifdef FIFO_READER_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q == S_LOAD) begin
      shift_d = fifo_data;
`ifdef FIFO_READER_PARITY_EN
      parity_d = ^fifo_data;
`endif
    end else if ((state_q == S_DATA) && bit_end) begin
      shift_d = {1'b0, shift_q[7:1]};
    end
  end

  // Line level and completion pulse, both registered off the current state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef FIFO_READER_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
    byte_done_d = (state_q == S_STOP) && bit_end;
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      byte_done_q <= 1'b0;
`ifdef FIFO_READER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      byte_done_q <= byte_done_d;
`ifdef FIFO_READER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign fifo_pop  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign tx_line   = tx_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_fifo_serial_reader.sv
// Bench for fifo_serial_reader: a queue-based FIFO model feeds the reader,
// every pushed byte is also queued as an expected frame, and each frame the
// reader launches is compared cycle by cycle against that expectation.
module tb_fifo_serial_reader;

  localparam int CPB = 4;
`ifdef FIFO_READER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * CPB;

  logic       clk;
  logic       reset;
  logic       tx_enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop;
  logic       tx_line;
  logic       busy;
  logic       byte_done;

  int vectors;
  int miscompares;
  int cyc;
  int pops;
  int last_load;
  logic       last_par;
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];

  fifo_serial_reader #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .tx_line    (tx_line),
    .busy       (busy),
    .byte_done  (byte_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void refresh_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
  endfunction

  // One clock; the FIFO pops on the same edge that ends LOAD.
  task automatic tick();
    logic pop_pre;
    logic emp_pre;
    pop_pre = fifo_pop;
    emp_pre = fifo_empty;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_pre === 1'b1) begin
      pops++;
      vectors++;
      if (emp_pre) begin
        $display("FAIL pop_when_empty: fifo_pop=1 with fifo_empty=1 at cycle %0d, required no pop", cyc);
        miscompares++;
      end else begin
        void'(fq.pop_front());
      end
    end
    refresh_fifo();
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    refresh_fifo();
  endtask

  task automatic wait_load(output int tl, output bit ok);
    ok = 1'b0;
    tl = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (fifo_pop === 1'b1) begin
        ok = 1'b1;
        tl = cyc;
      end else begin
        tick();
      end
    end
  endtask

  // Waits for LOAD, then checks line, busy, byte_done and pop for the whole
  // frame plus the first IDLE cycle. The line falls two cycles after LOAD.
  task automatic check_frame(input int exp_gap, input int drop_at);
    int         tl;
    bit         ok;
    logic [7:0] exp_b;
    logic [10:0] bits;
    logic [7:0] rx;
    int         idx;
    int         sub;
    logic       e_tx;
    int         bad_tx, bad_busy, bad_bd, bad_pop;
    bad_tx = -1; bad_busy = -1; bad_bd = -1; bad_pop = -1;
    rx = 8'h00;
    wait_load(tl, ok);
    vectors++;
    if (!ok) begin
      $display("FAIL load_wait: no fifo_pop within 300 cycles, required a LOAD");
      miscompares++;
      return;
    end
    if (exp_gap > 0) begin
      vectors++;
      if (tl - last_load != exp_gap) begin
        $display("FAIL frame_period: got %0d cycles, required %0d", tl - last_load, exp_gap);
        miscompares++;
      end
    end
    last_load = tl;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard: frame launched with no byte expected");
      miscompares++;
      return;
    end
    exp_b = exp_q.pop_front();
`ifdef FIFO_READER_PARITY_EN
    bits = {1'b1, ^exp_b, exp_b, 1'b0};
`else
    bits = {1'b0, 1'b1, exp_b, 1'b0};
`endif
    for (int c = 1; c <= F + 1; c++) begin
      tick();
      if (c == drop_at) tx_enable = 1'b0;
      e_tx = 1'b1;
      if (c >= 2) begin
        idx  = (c - 2) / CPB;
        sub  = (c - 2) % CPB;
        e_tx = bits[idx];
        if (sub == CPB / 2) begin
          if (idx >= 1 && idx <= 8) rx[idx-1] = tx_line;
          if (idx == 9) last_par = tx_line;
        end
      end
      if (tx_line !== e_tx && bad_tx < 0) bad_tx = c;
      if (busy !== (c <= F) && bad_busy < 0) bad_busy = c;
      if (byte_done !== (c == F + 1) && bad_bd < 0) bad_bd = c;
      if (fifo_pop !== 1'b0 && bad_pop < 0) bad_pop = c;
    end
    vectors += 5;
    if (bad_tx >= 0) begin
      $display("FAIL tx_line: byte %h wrong level at LOAD+%0d, required bit %0d of frame", exp_b, bad_tx, (bad_tx - 2) / CPB);
      miscompares++;
    end
    if (bad_busy >= 0) begin
      $display("FAIL busy: wrong at LOAD+%0d, required high through LOAD+%0d only", bad_busy, F);
      miscompares++;
    end
    if (bad_bd >= 0) begin
      $display("FAIL byte_done: wrong at LOAD+%0d, required single pulse at LOAD+%0d", bad_bd, F + 1);
      miscompares++;
    end
    if (bad_pop >= 0) begin
      $display("FAIL pop_width: fifo_pop high at LOAD+%0d, required one-cycle pulse", bad_pop);
      miscompares++;
    end
    if (rx !== exp_b) begin
      $display("FAIL rx_byte: decoded %h, required %h", rx, exp_b);
      miscompares++;
    end
  endtask

  // Idle-line watch: no pops, line high, not busy, no byte_done.
  task automatic check_quiet(input int n, input string tag);
    int p0;
    int bad;
    p0 = pops;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx_line !== 1'b1 || busy !== 1'b0 || byte_done !== 1'b0 || fifo_pop !== 1'b0) bad++;
    end
    vectors += 2;
    if (pops != p0) begin
      $display("FAIL %s_pops: %0d pops, required 0", tag, pops - p0);
      miscompares++;
    end
    if (bad != 0) begin
      $display("FAIL %s_line: %0d cycles not idle, required 0", tag, bad);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tx_enable = 1'b0;
    refresh_fifo();
    #3;
    reset = 1'b1;
    #1;
    vectors += 4;
    if (tx_line !== 1'b1) begin $display("FAIL reset_tx_line: got %b, required 1", tx_line); miscompares++; end
    if (fifo_pop !== 1'b0) begin $display("FAIL reset_fifo_pop: got %b, required 0", fifo_pop); miscompares++; end
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b, required 0", busy); miscompares++; end
    if (byte_done !== 1'b0) begin $display("FAIL reset_byte_done: got %b, required 0", byte_done); miscompares++; end
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;
    tx_enable = 1'b1;
    check_quiet(50, "empty_idle");
  endtask

  task automatic test_single();
    int p0;
    p0 = pops;
    push(8'hA5);
    check_frame(0, 0);
    vectors++;
    if (pops - p0 != 1) begin
      $display("FAIL single_pops: got %0d, required 1", pops - p0);
      miscompares++;
    end
  endtask

  task automatic test_burst();
    int p0;
    p0 = pops;
    tx_enable = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    tx_enable = 1'b1;
    for (int i = 0; i < 4; i++) check_frame((i == 0) ? 0 : F + 2, 0);
    vectors += 3;
    if (pops - p0 != 4) begin $display("FAIL burst_pops: got %0d, required 4", pops - p0); miscompares++; end
    if (fifo_empty !== 1'b1) begin $display("FAIL burst_empty: got %b, required 1", fifo_empty); miscompares++; end
    if (busy !== 1'b0) begin $display("FAIL burst_busy: got %b, required 0", busy); miscompares++; end
  endtask

  task automatic test_enable_drop();
    int p0;
    p0 = pops;
    tx_enable = 1'b0;
    push(8'h11);
    push(8'h22);
    tx_enable = 1'b1;
    check_frame(0, 10);
    check_quiet(30, "enable_drop");
    vectors++;
    if (pops - p0 != 1) begin $display("FAIL drop_pops: got %0d, required 1", pops - p0); miscompares++; end
    tx_enable = 1'b1;
    check_frame(0, 0);
  endtask

  task automatic test_reset_mid();
    int tl;
    bit ok;
    int p0;
    p0 = pops;
    push(8'h5A);
    push(8'hC3);
    wait_load(tl, ok);
    vectors++;
    if (!ok) begin
      $display("FAIL mid_load_wait: no fifo_pop within 300 cycles, required a LOAD");
      miscompares++;
      return;
    end
    while (cyc < tl + 18) tick();
    #2;
    reset = 1'b1;
    #1;
    vectors += 3;
    if (tx_line !== 1'b1) begin $display("FAIL mid_reset_tx_line: got %b, required 1", tx_line); miscompares++; end
    if (busy !== 1'b0) begin $display("FAIL mid_reset_busy: got %b, required 0", busy); miscompares++; end
    if (fifo_pop !== 1'b0) begin $display("FAIL mid_reset_pop: got %b, required 0", fifo_pop); miscompares++; end
    void'(exp_q.pop_front());
    tick();
    tick();
    reset = 1'b0;
    check_frame(0, 0);
    vectors += 2;
    if (pops - p0 != 2) begin $display("FAIL mid_pops: got %0d, required 2", pops - p0); miscompares++; end
    if (fifo_empty !== 1'b1) begin $display("FAIL mid_empty: got %b, required 1", fifo_empty); miscompares++; end
  endtask

`ifdef FIFO_READER_PARITY_EN
  task automatic test_parity();
    push(8'h07);
    push(8'h03);
    check_frame(0, 0);
    vectors++;
    if (last_par !== 1'b1) begin $display("FAIL parity_07: got %b, required 1", last_par); miscompares++; end
    check_frame(F + 2, 0);
    vectors++;
    if (last_par !== 1'b0) begin $display("FAIL parity_03: got %b, required 0", last_par); miscompares++; end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    pops = 0;
    last_load = 0;
    last_par = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_enable_drop();
    test_reset_mid();
`ifdef FIFO_READER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
